dec_stage_p: RTL and testbench

- Parametrised next-generation decode stage for the pipelined MIPS core.
- Contains a configurable register file with write-through bypass and three-way operand forwarding (RF / M / W).
- Resolves branch compare flags and the next branch address in D.
- Registers the decoded bundle into a D/E pipeline register with stall and flush control.

---
 rtl/dec_pkg.sv | 30 +++
 rtl/dec_stage_p_regfile.sv | 28 ++
 rtl/dec_stage_p.sv | 96 +++++++++
 tb/tb_dec_stage_p.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// dec_pkg: shared constants, instruction field positions and the D/E control bundle.
package dec_pkg;
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_M = 2'd1;
  localparam logic [1:0] FWD_W = 2'd2;
  localparam logic [1:0] BR_TGT = 2'd0;
  localparam logic [1:0] BR_JMP = 2'd1;
  localparam logic [1:0] BR_REG = 2'd2;
  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;
  localparam int FN_HI = 5;
  localparam int FN_LO = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int JMP_HI = 25;
  typedef struct packed {
    logic valid;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } dec_e_t;
endpackage

// File: rtl/dec_stage_p_regfile.sv
// regfile_p: 2R/1W register file with write-through bypass and optional hardwired zero register.
module regfile_p #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW = $clog2(NREG),
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   raddr_a,
  input  logic [AW-1:0]   raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);
  logic [XLEN-1:0] mem [NREG];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    else if (we && !(ZERO_REG != 0 && waddr == '0))
      mem[waddr] <= wdata;
  always_comb begin
    rdata_a = (ZERO_REG != 0 && raddr_a == '0) ? '0 : (we && raddr_a == waddr) ? wdata : mem[raddr_a];
    rdata_b = (ZERO_REG != 0 && raddr_b == '0) ? '0 : (we && raddr_b == waddr) ? wdata : mem[raddr_b];
  end
endmodule

// File: rtl/dec_stage_p.sv
// dec_stage_p: MIPS decode stage with RF read, operand forwarding, branch resolution
// and a stallable/flushable D/E pipeline register.
module dec_stage_p
  import dec_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW = $clog2(NREG),
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     inst_D,
  input  logic [XLEN-1:0] pc_plus4_D,
  input  logic            valid_D,
  input  logic            unsigned_D,
  input  logic            we_W,
  input  logic [AW-1:0]   waddr_W,
  input  logic [XLEN-1:0] wdata_W,
  input  logic [XLEN-1:0] alu_out_M,
  input  logic [1:0]      fwd_a_sel,
  input  logic [1:0]      fwd_b_sel,
  input  logic [1:0]      branch_src,
  input  logic            stall_E,
  input  logic            flush_E,
  output logic [XLEN-1:0] next_br_D,
  output logic            a_eq_b_D,
  output logic            a_eq_z_D,
  output logic            a_gt_z_D,
  output logic            a_lt_z_D,
  output logic            valid_E,
  output logic [5:0]      opcode_E,
  output logic [5:0]      funct_E,
  output logic [4:0]      rs_E,
  output logic [4:0]      rt_E,
  output logic [4:0]      rd_E,
  output logic [XLEN-1:0] src_a_E,
  output logic [XLEN-1:0] src_b_E,
  output logic [XLEN-1:0] imm_E
);
  logic [XLEN-1:0] rf_a, rf_b, src_a_D, src_b_D, imm_D, br_tgt, jmp_tgt;
  logic [XLEN-1:0] src_a_q, src_b_q, imm_q;
  dec_e_t e_d, e_q;
  regfile_p #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .ZERO_REG(ZERO_REG)) u_rf (
    .clk(clk),
    .rst_n(rst_n),
    .raddr_a(inst_D[RS_LO +: AW]),
    .raddr_b(inst_D[RT_LO +: AW]),
    .rdata_a(rf_a),
    .rdata_b(rf_b),
    .we(we_W),
    .waddr(waddr_W),
    .wdata(wdata_W)
  );
  always_comb begin
    src_a_D = fwd_a_sel == FWD_M ? alu_out_M : fwd_a_sel == FWD_W ? wdata_W : rf_a;
    src_b_D = fwd_b_sel == FWD_M ? alu_out_M : fwd_b_sel == FWD_W ? wdata_W : rf_b;
    imm_D = {{(XLEN-16){~unsigned_D & inst_D[IMM_HI]}}, inst_D[IMM_HI:IMM_LO]};
    br_tgt = pc_plus4_D + (imm_D << 2);
    jmp_tgt = {pc_plus4_D[XLEN-1:28], inst_D[JMP_HI:0], 2'b00};
    next_br_D = branch_src == BR_JMP ? jmp_tgt : branch_src == BR_REG ? src_a_D : br_tgt;
    e_d = '{valid: valid_D, opcode: inst_D[OP_HI:OP_LO], funct: inst_D[FN_HI:FN_LO],
            rs: inst_D[RS_HI:RS_LO], rt: inst_D[RT_HI:RT_LO], rd: inst_D[RD_HI:RD_LO]};
  end
  assign a_eq_b_D = src_a_D == src_b_D;
  assign a_eq_z_D = src_a_D == '0;
  assign a_lt_z_D = src_a_D[XLEN-1];
  assign a_gt_z_D = ~src_a_D[XLEN-1] & |src_a_D;
  // flush outranks stall so a squashed slot never survives a held pipeline
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      e_q <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      imm_q <= '0;
    end else if (flush_E) begin
      e_q <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      imm_q <= '0;
    end else if (!stall_E) begin
      e_q <= e_d;
      src_a_q <= src_a_D;
      src_b_q <= src_b_D;
      imm_q <= imm_D;
    end
  assign valid_E = e_q.valid;
  assign opcode_E = e_q.opcode;
  assign funct_E = e_q.funct;
  assign rs_E = e_q.rs;
  assign rt_E = e_q.rt;
  assign rd_E = e_q.rd;
  assign src_a_E = src_a_q;
  assign src_b_E = src_b_q;
  assign imm_E = imm_q;
endmodule

// File: tb/tb_dec_stage_p.sv
// tb_dec_stage_p: directed stimulus with a reference model checked every cycle plus literal pins.
module tb_dec_stage_p;
  logic clk = 0, rst_n = 0;
  logic [31:0] inst_D = 0, pc_plus4_D = 0, wdata_W = 0, alu_out_M = 0;
  logic valid_D = 0, unsigned_D = 0, we_W = 0, stall_E = 0, flush_E = 0;
  logic [4:0] waddr_W = 0;
  logic [1:0] fwd_a_sel = 0, fwd_b_sel = 0, branch_src = 0;
  logic [31:0] next_br_D, src_a_E, src_b_E, imm_E;
  logic a_eq_b_D, a_eq_z_D, a_gt_z_D, a_lt_z_D, valid_E;
  logic [5:0] opcode_E, funct_E;
  logic [4:0] rs_E, rt_E, rd_E;
  int checks = 0, errors = 0;

  dec_stage_p dut (
    .clk(clk), .rst_n(rst_n), .inst_D(inst_D), .pc_plus4_D(pc_plus4_D), .valid_D(valid_D),
    .unsigned_D(unsigned_D), .we_W(we_W), .waddr_W(waddr_W), .wdata_W(wdata_W),
    .alu_out_M(alu_out_M), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .branch_src(branch_src), .stall_E(stall_E), .flush_E(flush_E), .next_br_D(next_br_D),
    .a_eq_b_D(a_eq_b_D), .a_eq_z_D(a_eq_z_D), .a_gt_z_D(a_gt_z_D), .a_lt_z_D(a_lt_z_D),
    .valid_E(valid_E), .opcode_E(opcode_E), .funct_E(funct_E), .rs_E(rs_E), .rt_E(rt_E),
    .rd_E(rd_E), .src_a_E(src_a_E), .src_b_E(src_b_E), .imm_E(imm_E)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] m_rf [32];
  logic m_valid;
  logic [5:0] m_op, m_fn;
  logic [4:0] m_rs, m_rt, m_rd;
  logic [31:0] m_a, m_b, m_imm;

  function automatic logic [31:0] rf_rd(input int a);
    if (a == 0) return 0;
    if (we_W && int'(waddr_W) == a) return wdata_W;
    return m_rf[a];
  endfunction

  function automatic logic [31:0] opnd(input logic [1:0] sel, input int a);
    if (sel == 1) return alu_out_M;
    if (sel == 2) return wdata_W;
    return rf_rd(a);
  endfunction

  function automatic logic [31:0] imm_ext();
    logic [15:0] h = inst_D[15:0];
    int s = $signed(h);
    return unsigned_D ? {16'h0, h} : 32'(s);
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      foreach (m_rf[i]) m_rf[i] <= 0;
      {m_valid, m_op, m_fn, m_rs, m_rt, m_rd, m_a, m_b, m_imm} <= '0;
    end else begin
      if (flush_E)
        {m_valid, m_op, m_fn, m_rs, m_rt, m_rd, m_a, m_b, m_imm} <= '0;
      else if (!stall_E) begin
        m_valid <= valid_D;
        m_op <= inst_D[31:26];
        m_fn <= inst_D[5:0];
        m_rs <= inst_D[25:21];
        m_rt <= inst_D[20:16];
        m_rd <= inst_D[15:11];
        m_a <= opnd(fwd_a_sel, int'(inst_D[25:21]));
        m_b <= opnd(fwd_b_sel, int'(inst_D[20:16]));
        m_imm <= imm_ext();
      end
      if (we_W && waddr_W != 0) m_rf[waddr_W] <= wdata_W;
    end

  always @(negedge clk)
    if (rst_n) begin
      logic [31:0] a, b, tgt;
      a = opnd(fwd_a_sel, int'(inst_D[25:21]));
      b = opnd(fwd_b_sel, int'(inst_D[20:16]));
      tgt = branch_src == 1 ? {pc_plus4_D[31:28], inst_D[25:0], 2'b00}
          : branch_src == 2 ? a : pc_plus4_D + imm_ext() * 4;
      chk("next_br", next_br_D, tgt);
      chk("flags", {28'd0, a_eq_b_D, a_eq_z_D, a_gt_z_D, a_lt_z_D},
          {28'd0, a == b, a == 0, $signed(a) > 0, $signed(a) < 0});
      chk("e_ctrl", {4'd0, valid_E, opcode_E, funct_E, rs_E, rt_E, rd_E},
          {4'd0, m_valid, m_op, m_fn, m_rs, m_rt, m_rd});
      chk("src_a_E", src_a_E, m_a);
      chk("src_b_E", src_b_E, m_b);
      chk("imm_E", imm_E, m_imm);
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) step();
    chk("rst_valid", {31'd0, valid_E}, 0);
    chk("rst_src_a", src_a_E, 0);
    rst_n = 1;
    step();
    we_W = 1; waddr_W = 5; wdata_W = 32'h1234;
    step();
    we_W = 0; inst_D = 32'h20A00000; valid_D = 1;
    step();
    chk("rf_src_a_E", src_a_E, 32'h1234);
    chk("rf_valid_E", {31'd0, valid_E}, 1);
    we_W = 1; waddr_W = 7; wdata_W = 32'hCAFE; inst_D = 32'h20E00000; branch_src = 2;
    #1 chk("bypass", next_br_D, 32'hCAFE);
    chk("bypass_eqz", {31'd0, a_eq_z_D}, 0);
    step();
    waddr_W = 0; wdata_W = 32'hFF; inst_D = 32'h20000000;
    #1 chk("r0_bypass", next_br_D, 0);
    chk("r0_eqz", {31'd0, a_eq_z_D}, 1);
    step();
    we_W = 0;
    #1 chk("r0_read", next_br_D, 0);
    we_W = 1; waddr_W = 3; wdata_W = 1; inst_D = 32'h20630000;
    step();
    we_W = 0; alu_out_M = 10; wdata_W = 20; fwd_a_sel = 1; fwd_b_sel = 2;
    #1 chk("fwd_eqb", {31'd0, a_eq_b_D}, 0);
    step();
    chk("fwd_a_E", src_a_E, 10);
    chk("fwd_b_E", src_b_E, 20);
    fwd_a_sel = 3;
    #1 chk("fwd_sel3", next_br_D, 1);
    fwd_a_sel = 0; fwd_b_sel = 0;
    #1 chk("rf_eqb", {31'd0, a_eq_b_D}, 1);
    wdata_W = 0; pc_plus4_D = 32'h00400004; inst_D = 32'h1000FFFF; branch_src = 0;
    #1 chk("br_sext", next_br_D, 32'h00400000);
    unsigned_D = 1;
    #1 chk("br_zext", next_br_D, 32'h00440000);
    unsigned_D = 0; branch_src = 1; inst_D = 32'h08000010;
    #1 chk("jmp", next_br_D, 32'h00000040);
    alu_out_M = 32'h80000000; fwd_a_sel = 1;
    #1 chk("neg_flags", {30'd0, a_gt_z_D, a_lt_z_D}, 32'h1);
    step();
    fwd_a_sel = 0; branch_src = 0; inst_D = 32'h012A4020; valid_D = 1;
    step();
    chk("load_A", {valid_E, opcode_E, funct_E, rs_E, rt_E, rd_E}, {1'b1, 6'h0, 6'h20, 5'd9, 5'd10, 5'd8});
    stall_E = 1; inst_D = 32'h20630000; valid_D = 0;
    repeat (2) step();
    chk("stall_A", {valid_E, opcode_E, funct_E, rs_E, rt_E, rd_E}, {1'b1, 6'h0, 6'h20, 5'd9, 5'd10, 5'd8});
    flush_E = 1;
    step();
    chk("flush", {valid_E, opcode_E, funct_E, rs_E, rt_E, rd_E}, 0);
    stall_E = 0; flush_E = 0; inst_D = 32'h012A4020; valid_D = 1;
    step();
    chk("pre_rst_valid", {31'd0, valid_E}, 1);
    rst_n = 0;
    #1 chk("async_rst", {31'd0, valid_E}, 0);
    step();
    rst_n = 1; inst_D = 32'h20A00000; branch_src = 2;
    #1 chk("r5_cleared", next_br_D, 0);
    inst_D = 32'h20600000;
    #1 chk("r3_cleared", next_br_D, 0);
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
